// File: rtl/s382_resp_misr_if.sv
// rtl/s382_resp_misr_if.sv - control, capture and signature handshake bundle for the s382 response MISR
interface s382_resp_misr_if #(
    parameter int SIG_W = 16,
    parameter int IN_W  = 6
);
    logic             start;
    logic [15:0]      num_cycles;
    logic [SIG_W-1:0] golden;
    logic [IN_W-1:0]  po_in;
    logic             busy;
    logic             sig_valid;
    logic             sig_ready;
    logic [SIG_W-1:0] sig_out;
    logic             match;
    logic [15:0]      cycle_cnt;

    modport master (
        output start, num_cycles, golden, po_in, sig_ready,
        input  busy, sig_valid, sig_out, match, cycle_cnt
    );

    modport slave (
        input  start, num_cycles, golden, po_in, sig_ready,
        output busy, sig_valid, sig_out, match, cycle_cnt
    );
endinterface

// File: rtl/s382_resp_misr.sv
// rtl/s382_resp_misr.sv - multiple-input signature register compacting the s382 core outputs
module s382_resp_misr #(
    parameter int               SIG_W = 16,
    parameter int               IN_W  = 6,
    parameter logic [SIG_W-1:0] POLY  = 16'h1021,
    parameter logic [SIG_W-1:0] SEED  = 16'h0000,
    parameter int               SKIP  = 2
) (
    input logic           clock,
    input logic           reset,
    s382_resp_misr_if.slave bus
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SETTLE  = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam int              SKIP_W    = (SKIP > 1) ? $clog2(SKIP) : 1;
    localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'((SKIP > 0) ? SKIP - 1 : 0);

    logic [1:0]       r_state;
    logic [SIG_W-1:0] r_sig;
    logic [15:0]      r_cnt;
    logic [SKIP_W-1:0] r_skip;
    logic [15:0]      r_num;
    logic [SIG_W-1:0] r_golden;

    logic [SIG_W-1:0] w_po_ext;
    logic [SIG_W-1:0] w_sig_next;
    logic [15:0]      w_cnt_inc;
    logic [1:0]       w_after_start;
    logic [1:0]       w_after_settle;

    always_comb begin
        w_po_ext = '0;
        w_po_ext[IN_W-1:0] = bus.po_in;
    end

    // Shift left, fold the outgoing MSB back through the taps, then inject the sample.
    assign w_sig_next = {r_sig[SIG_W-2:0], 1'b0}
                      ^ (r_sig[SIG_W-1] ? POLY : '0)
                      ^ w_po_ext;

    assign w_cnt_inc = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;

    // A zero-length window never enters CAPTURE, so no sample is ever folded in.
    assign w_after_settle = (r_num == 16'd0) ? ST_DONE : ST_CAPTURE;
    assign w_after_start  = (SKIP > 0)              ? ST_SETTLE :
                            (bus.num_cycles == 16'd0) ? ST_DONE : ST_CAPTURE;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_sig    <= SEED;
            r_cnt    <= 16'd0;
            r_skip   <= '0;
            r_num    <= 16'd0;
            r_golden <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_num    <= bus.num_cycles;
                        r_golden <= bus.golden;
                        r_sig    <= SEED;
                        r_cnt    <= 16'd0;
                        r_skip   <= '0;
                        r_state  <= w_after_start;
                    end
                end
                ST_SETTLE: begin
                    r_skip <= r_skip + 1'b1;
                    if (r_skip == SKIP_LAST) begin
                        r_state <= w_after_settle;
                    end
                end
                ST_CAPTURE: begin
                    r_sig <= w_sig_next;
                    r_cnt <= w_cnt_inc;
                    if (w_cnt_inc >= r_num) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.sig_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy      = (r_state == ST_SETTLE) || (r_state == ST_CAPTURE);
    assign bus.sig_valid = (r_state == ST_DONE);
    assign bus.sig_out   = r_sig;
    assign bus.cycle_cnt = r_cnt;
    assign bus.match     = (r_state == ST_DONE) && (r_sig == r_golden);
endmodule
